// File: rtl/palette_reader_if.sv
// palette_reader_if
//   Bundles every non-clock/reset signal of palette_reader.
//   master : pixel source, mask/control registers, palette RAM and video sink
//            (the side that feeds the block and consumes its stream)
//   slave  : the palette_reader itself
//   Signal groups:
//     pixel in     line_start, pix_valid, pix_ready, bg_pat, bg_attr, spr_pat,
//                  spr_pal, spr_behind, spr_zero
//     mask/control show_bg, show_spr, show_bg_left, show_spr_left, greyscale,
//                  emphasis, sprite0_clear
//     palette RAM  pram_addr (to RAM), pram_data (from RAM, combinational)
//     video out    out_valid, out_ready, out_color, out_emph
//     status       sprite0_hit
interface palette_reader_if;
   logic       line_start;
   logic       pix_valid;
   logic       pix_ready;
   logic [1:0] bg_pat;
   logic [1:0] bg_attr;
   logic [1:0] spr_pat;
   logic [1:0] spr_pal;
   logic       spr_behind;
   logic       spr_zero;
   logic       show_bg;
   logic       show_spr;
   logic       show_bg_left;
   logic       show_spr_left;
   logic       greyscale;
   logic [2:0] emphasis;
   logic [4:0] pram_addr;
   logic [5:0] pram_data;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_color;
   logic [2:0] out_emph;
   logic       sprite0_hit;
   logic       sprite0_clear;

   modport master (
      output line_start, pix_valid, bg_pat, bg_attr, spr_pat, spr_pal,
             spr_behind, spr_zero, show_bg, show_spr, show_bg_left,
             show_spr_left, greyscale, emphasis, pram_data, out_ready,
             sprite0_clear,
      input  pix_ready, pram_addr, out_valid, out_color, out_emph, sprite0_hit
   );

   modport slave (
      input  line_start, pix_valid, bg_pat, bg_attr, spr_pat, spr_pal,
             spr_behind, spr_zero, show_bg, show_spr, show_bg_left,
             show_spr_left, greyscale, emphasis, pram_data, out_ready,
             sprite0_clear,
      output pix_ready, pram_addr, out_valid, out_color, out_emph, sprite0_hit
   );
endinterface

// File: rtl/palette_reader.sv
// palette_reader
//   Read-side consumer of the palette RAM. Resolves background/sprite priority
//   with left-column masking, forms the 5-bit palette address, reads the RAM,
//   applies greyscale and streams {emphasis, colour} through a small FIFO.
//   Also raises a sticky sprite-0 hit flag.
// Ports
//   clock  system clock
//   reset  synchronous, active-high
//   bus    palette_reader_if.slave (pixel in, controls, palette RAM, video out)
// Handshakes (both valid/ready): a transfer happens on a rising edge where
//   valid && ready are both high. valid/data are held by the producer until the
//   transfer; ready may change freely and never depends on valid.
//   pixel in : pix_valid / pix_ready
//   video out: out_valid / out_ready
module palette_reader #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   palette_reader_if.slave  bus
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // pixel intake / stage 1
   logic [7:0]    x_cnt;
   logic [7:0]    pix_x;
   logic          accept;
   logic          bg_op;
   logic          sp_op;
   logic          s0_set;
   logic [4:0]    addr_d;
   logic [4:0]    pram_addr_q;
   logic          s1_valid;
   logic          s1_grey;
   logic [2:0]    s1_emph;
   logic          hit_q;

   // stage 2 / output FIFO
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] occupancy;
   logic [8:0]    push_word;
   logic [8:0]    hold_word;
   logic [8:0]    head_word;
   logic          push;
   logic          pop;
   logic          empty;

   // The pixel sitting in stage 1 is counted against the FIFO, so it always
   // has a slot reserved when it is written one cycle later.
   assign occupancy     = count + CW'(s1_valid);
   assign bus.pix_ready = (occupancy < DEPTH_C);
   assign accept        = bus.pix_valid && bus.pix_ready;

   assign pix_x = bus.line_start ? 8'd0 : x_cnt;

   // x>=8 is simply "any of bits 7..3 set"
   assign bg_op = bus.show_bg && (bus.bg_pat != 2'd0)
                  && ((pix_x[7:3] != 5'd0) || bus.show_bg_left);
   assign sp_op = bus.show_spr && (bus.spr_pat != 2'd0)
                  && ((pix_x[7:3] != 5'd0) || bus.show_spr_left);

   // Transparent pixels always map to entry 0, never to the 0x10/14/18/1C mirrors.
   always_comb begin
      addr_d = 5'h00;
      if (sp_op && (!bg_op || !bus.spr_behind)) begin
         addr_d = {1'b1, bus.spr_pal, bus.spr_pat};
      end else if (bg_op) begin
         addr_d = {1'b0, bus.bg_attr, bus.bg_pat};
      end
   end

   // Sprite-0 hit ignores the priority bit and never fires at x=255.
   assign s0_set = accept && bus.spr_zero && bg_op && sp_op && (pix_x != 8'hFF);

   always_ff @(posedge clock) begin
      if (reset) begin
         x_cnt       <= 8'd0;
         pram_addr_q <= 5'h00;
         s1_valid    <= 1'b0;
         s1_grey     <= 1'b0;
         s1_emph     <= 3'd0;
         hit_q       <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            x_cnt       <= pix_x + 8'd1;
            pram_addr_q <= addr_d;
            s1_grey     <= bus.greyscale;
            s1_emph     <= bus.emphasis;
         end
         // clear beats a same-cycle set
         if (bus.sprite0_clear) begin
            hit_q <= 1'b0;
         end else if (s0_set) begin
            hit_q <= 1'b1;
         end
      end
   end

   // Stage 2: RAM data is combinational from the registered address.
   assign push      = s1_valid;
   assign push_word = {s1_emph, s1_grey ? (bus.pram_data & 6'h30) : bus.pram_data};

   assign empty     = (count == CW'(0));
   assign pop       = !empty && bus.out_ready;
   assign head_word = empty ? hold_word : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         hold_word <= 9'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            hold_word <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.pram_addr   = pram_addr_q;
   assign bus.out_valid   = !empty;
   assign bus.out_color   = head_word[5:0];
   assign bus.out_emph    = head_word[8:6];
   assign bus.sprite0_hit = hit_q;
endmodule
